// File: rtl/command_executor_pkg.sv
// Shared opcode and state definitions for the command executor and its state bank.
package command_executor_pkg;

    typedef enum logic [15:0] {
        NOP                 = 16'd0,
        END                 = 16'd1,
        SET_CLEAR_COLOR_LO  = 16'd2,
        SET_CLEAR_COLOR_HI  = 16'd3,
        SET_VIEWPORT_WIDTH  = 16'd4,
        SET_VIEWPORT_HEIGHT = 16'd5,
        SET_VERTEX_BASE_LO  = 16'd6,
        SET_VERTEX_BASE_HI  = 16'd7,
        CLEAR               = 16'd8,
        DRAW                = 16'd9
    } CommandOperands;

    typedef enum logic [2:0] {
        FETCH,
        ACK,
        EXECUTE,
        WAIT_CLEAR,
        WAIT_DRAW
    } exec_state_t;

    localparam int unsigned HALF_WIDTH = 16;

    // Opcodes are dense from NOP up to DRAW; anything above is illegal.
    function automatic logic is_legal_op(input logic [15:0] op);
        return op <= DRAW;
    endfunction

endpackage

// File: rtl/command_state_bank.sv
// Render-state registers, written one field at a time by opcode when wr_en is high.
module command_state_bank
    import command_executor_pkg::*;
#(
    parameter int unsigned CMD_DATA_WIDTH    = 16,
    parameter int unsigned VERTEX_ADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [15:0]                  opcode,
    input  logic [CMD_DATA_WIDTH-1:0]    data,
    output logic [31:0]                  clear_color,
    output logic [15:0]                  viewport_width,
    output logic [15:0]                  viewport_height,
    output logic [VERTEX_ADDR_WIDTH-1:0] vertex_base,
    output logic [15:0]                  draw_count
);

    logic [31:0]                  clear_color_q, clear_color_d;
    logic [15:0]                  viewport_width_q, viewport_width_d;
    logic [15:0]                  viewport_height_q, viewport_height_d;
    logic [VERTEX_ADDR_WIDTH-1:0] vertex_base_q, vertex_base_d;
    logic [15:0]                  draw_count_q, draw_count_d;

    always_comb begin
        clear_color_d     = clear_color_q;
        viewport_width_d  = viewport_width_q;
        viewport_height_d = viewport_height_q;
        vertex_base_d     = vertex_base_q;
        draw_count_d      = draw_count_q;
        if (wr_en) begin
            case (opcode)
                SET_CLEAR_COLOR_LO:  clear_color_d[15:0]  = data[HALF_WIDTH-1:0];
                SET_CLEAR_COLOR_HI:  clear_color_d[31:16] = data[HALF_WIDTH-1:0];
                SET_VIEWPORT_WIDTH:  viewport_width_d     = data[HALF_WIDTH-1:0];
                SET_VIEWPORT_HEIGHT: viewport_height_d    = data[HALF_WIDTH-1:0];
                SET_VERTEX_BASE_LO:  vertex_base_d[HALF_WIDTH-1:0] = data[HALF_WIDTH-1:0];
                SET_VERTEX_BASE_HI:  vertex_base_d[VERTEX_ADDR_WIDTH-1:HALF_WIDTH] =
                                         data[VERTEX_ADDR_WIDTH-HALF_WIDTH-1:0];
                DRAW:                draw_count_d         = data[HALF_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_color_q     <= '0;
            viewport_width_q  <= '0;
            viewport_height_q <= '0;
            vertex_base_q     <= '0;
            draw_count_q      <= '0;
        end else begin
            clear_color_q     <= clear_color_d;
            viewport_width_q  <= viewport_width_d;
            viewport_height_q <= viewport_height_d;
            vertex_base_q     <= vertex_base_d;
            draw_count_q      <= draw_count_d;
        end
    end

    assign clear_color     = clear_color_q;
    assign viewport_width  = viewport_width_q;
    assign viewport_height = viewport_height_q;
    assign vertex_base     = vertex_base_q;
    assign draw_count      = draw_count_q;

endmodule

// File: rtl/command_executor.sv
// Pulls decoded commands from the command processor, updates render state and
// hands CLEAR/DRAW requests to the back end over valid/ready.
//
// state      | meaning
// FETCH      | idle, latch command when aCommandReady
// ACK        | request pulse to processor so it advances
// EXECUTE    | apply latched opcode for one cycle
// WAIT_CLEAR | clear valid held until aClearReady
// WAIT_DRAW  | draw valid held until aDrawReady
module command_executor
    import command_executor_pkg::*;
#(
    parameter int unsigned CMD_DATA_WIDTH    = 16,
    parameter int unsigned VERTEX_ADDR_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH       = 16
) (
    input  logic                         aClock,
    input  logic                         aReset,
    input  logic                         aCommandReady,
    input  logic [15:0]                  aCommand,
    input  logic [CMD_DATA_WIDTH-1:0]    aCommandData,
    output logic                         anOutCommandRequested,
    output logic [31:0]                  anOutClearColor,
    output logic [15:0]                  anOutViewportWidth,
    output logic [15:0]                  anOutViewportHeight,
    output logic [VERTEX_ADDR_WIDTH-1:0] anOutVertexBase,
    output logic [15:0]                  anOutDrawCount,
    output logic                         anOutDrawValid,
    input  logic                         aDrawReady,
    output logic                         anOutClearValid,
    input  logic                         aClearReady,
    output logic                         anOutDone,
    output logic                         anOutError,
    output logic                         anOutBusy,
    output logic [COUNT_WIDTH-1:0]       anOutCommandCount
);

    exec_state_t               state_q, state_d;
    logic [15:0]               cmd_q, cmd_d;
    logic [CMD_DATA_WIDTH-1:0] data_q, data_d;
    logic                      error_q, error_d;
    logic [COUNT_WIDTH-1:0]    count_q, count_d;
    logic                      bank_wr;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        error_d = error_q;
        count_d = count_q;
        bank_wr = 1'b0;
        case (state_q)
            FETCH: begin
                if (aCommandReady) begin
                    cmd_d   = aCommand;
                    data_d  = aCommandData;
                    state_d = ACK;
                end
            end
            ACK: state_d = EXECUTE;
            EXECUTE: begin
                bank_wr = 1'b1;
                if (!is_legal_op(cmd_q)) begin
                    error_d = 1'b1;
                end
                // CLEAR/DRAW are only counted once the back end takes them.
                if (cmd_q == CLEAR) begin
                    state_d = WAIT_CLEAR;
                end else if (cmd_q == DRAW) begin
                    state_d = WAIT_DRAW;
                end else begin
                    state_d = FETCH;
                    count_d = count_q + COUNT_WIDTH'(1);
                end
            end
            WAIT_CLEAR: begin
                if (aClearReady) begin
                    state_d = FETCH;
                    count_d = count_q + COUNT_WIDTH'(1);
                end
            end
            WAIT_DRAW: begin
                if (aDrawReady) begin
                    state_d = FETCH;
                    count_d = count_q + COUNT_WIDTH'(1);
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge aClock or negedge aReset) begin
        if (!aReset) begin
            state_q <= FETCH;
            cmd_q   <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    command_state_bank #(
        .CMD_DATA_WIDTH   (CMD_DATA_WIDTH),
        .VERTEX_ADDR_WIDTH(VERTEX_ADDR_WIDTH)
    ) u_state_bank (
        .clk            (aClock),
        .rst_n          (aReset),
        .wr_en          (bank_wr),
        .opcode         (cmd_q),
        .data           (data_q),
        .clear_color    (anOutClearColor),
        .viewport_width (anOutViewportWidth),
        .viewport_height(anOutViewportHeight),
        .vertex_base    (anOutVertexBase),
        .draw_count     (anOutDrawCount)
    );

    // Valids are decoded from state so reset drops them without a clock edge.
    assign anOutCommandRequested = (state_q == ACK);
    assign anOutClearValid       = (state_q == WAIT_CLEAR);
    assign anOutDrawValid        = (state_q == WAIT_DRAW);
    assign anOutDone             = (state_q == EXECUTE) && (cmd_q == END);
    assign anOutBusy             = (state_q != FETCH);
    assign anOutError            = error_q;
    assign anOutCommandCount     = count_q;

endmodule

// File: tb/tb_command_executor.sv
// Scoreboard bench for command_executor: a processor model feeds commands, a
// reference model predicts render state and back-end transactions.
module tb_command_executor;
    import command_executor_pkg::*;

    logic        aClock = 1'b0;
    logic        aReset;
    logic        aCommandReady;
    logic [15:0] aCommand;
    logic [15:0] aCommandData;
    logic        anOutCommandRequested;
    logic [31:0] anOutClearColor;
    logic [15:0] anOutViewportWidth;
    logic [15:0] anOutViewportHeight;
    logic [31:0] anOutVertexBase;
    logic [15:0] anOutDrawCount;
    logic        anOutDrawValid;
    logic        aDrawReady;
    logic        anOutClearValid;
    logic        aClearReady;
    logic        anOutDone;
    logic        anOutError;
    logic        anOutBusy;
    logic [15:0] anOutCommandCount;

    command_executor dut (
        .aClock               (aClock),
        .aReset               (aReset),
        .aCommandReady        (aCommandReady),
        .aCommand             (aCommand),
        .aCommandData         (aCommandData),
        .anOutCommandRequested(anOutCommandRequested),
        .anOutClearColor      (anOutClearColor),
        .anOutViewportWidth   (anOutViewportWidth),
        .anOutViewportHeight  (anOutViewportHeight),
        .anOutVertexBase      (anOutVertexBase),
        .anOutDrawCount       (anOutDrawCount),
        .anOutDrawValid       (anOutDrawValid),
        .aDrawReady           (aDrawReady),
        .anOutClearValid      (anOutClearValid),
        .aClearReady          (aClearReady),
        .anOutDone            (anOutDone),
        .anOutError           (anOutError),
        .anOutBusy            (anOutBusy),
        .anOutCommandCount    (anOutCommandCount)
    );

    always #5 aClock = ~aClock;

    typedef struct {
        logic [15:0] op;
        logic [15:0] data;
    } cmd_t;

    typedef struct {
        int          kind;
        logic [63:0] val;
    } ev_t;

    cmd_t fq[$];
    ev_t  sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_req, last_cost;
    int req_pulses, done_pulses;
    int dv_cnt = 0, cv_cnt = 0;
    int drw_hold = 0, clr_hold = 0;
    bit clr_tied = 0;

    logic [31:0] m_cc, m_vb;
    logic [15:0] m_vw, m_vh, m_dc, m_count;
    logic        m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cc = '0; m_vb = '0; m_vw = '0; m_vh = '0; m_dc = '0; m_count = '0; m_err = 1'b0;
    endtask

    task automatic drive_feeder();
        if (fq.size() > 0) begin
            aCommandReady = 1'b1;
            aCommand      = fq[0].op;
            aCommandData  = fq[0].data;
        end else begin
            aCommandReady = 1'b0;
            aCommand      = '0;
            aCommandData  = '0;
        end
    endtask

    task automatic push_cmd(input logic [15:0] op, input logic [15:0] data);
        cmd_t c;
        c.op = op;
        c.data = data;
        fq.push_back(c);
        case (op)
            SET_CLEAR_COLOR_LO:  m_cc[15:0]  = data;
            SET_CLEAR_COLOR_HI:  m_cc[31:16] = data;
            SET_VIEWPORT_WIDTH:  m_vw = data;
            SET_VIEWPORT_HEIGHT: m_vh = data;
            SET_VERTEX_BASE_LO:  m_vb[15:0]  = data;
            SET_VERTEX_BASE_HI:  m_vb[31:16] = data;
            CLEAR:               sb.push_back('{kind: 8, val: {32'h0, m_cc}});
            DRAW: begin
                m_dc = data;
                sb.push_back('{kind: 9, val: {16'h0, m_vb, data}});
            end
            END:                 sb.push_back('{kind: 1, val: {48'h0, m_count}});
            NOP: ;
            default:             m_err = 1'b1;
        endcase
        m_count = m_count + 16'd1;
    endtask

    function automatic int op_cost(input logic [15:0] op);
        if (op == CLEAR) return 4 + clr_hold;
        if (op == DRAW)  return 4 + drw_hold;
        return 3;
    endfunction

    task automatic sb_pop(output ev_t ev);
        chk("scoreboard_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) ev = sb.pop_front();
        else ev = '{kind: -1, val: '0};
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_clear_color"}, anOutClearColor, m_cc);
        chk({tag, "_vp_width"}, anOutViewportWidth, m_vw);
        chk({tag, "_vp_height"}, anOutViewportHeight, m_vh);
        chk({tag, "_vertex_base"}, anOutVertexBase, m_vb);
        chk({tag, "_draw_count"}, anOutDrawCount, m_dc);
        chk({tag, "_error"}, anOutError, m_err);
        chk({tag, "_cmd_count"}, anOutCommandCount, m_count);
    endtask

    // One clock: advance, then sample outputs and drive inputs 1ns after the edge.
    task automatic tick();
        logic        p_req, p_dv, p_dr, p_cv, p_cr;
        logic [15:0] p_dc;
        logic [31:0] p_vb, p_cc;
        ev_t         ev;
        p_req = anOutCommandRequested;
        p_dv  = anOutDrawValid;
        p_dr  = aDrawReady;
        p_cv  = anOutClearValid;
        p_cr  = aClearReady;
        p_dc  = anOutDrawCount;
        p_vb  = anOutVertexBase;
        p_cc  = anOutClearColor;
        @(posedge aClock);
        #1;
        cyc++;
        if (p_req && fq.size() > 0) fq.delete(0);
        drive_feeder();

        if (anOutCommandRequested) begin
            chk("req_not_consecutive", p_req, 1'b0);
            if (last_req >= 0) chk("req_spacing", 64'(cyc - last_req), 64'(last_cost));
            last_req  = cyc;
            last_cost = (fq.size() > 0) ? op_cost(fq[0].op) : 3;
            req_pulses++;
        end

        if (p_dv && anOutDrawValid)
            chk("draw_payload_stable", {anOutVertexBase, anOutDrawCount}, {p_vb, p_dc});
        if (p_dv && p_dr) begin
            sb_pop(ev);
            chk("draw_kind", 64'(ev.kind), 64'd9);
            chk("draw_payload", {p_vb, p_dc}, ev.val);
            chk("draw_valid_cycles", 64'(dv_cnt), 64'(drw_hold + 1));
            chk("draw_valid_drop", anOutDrawValid, 1'b0);
            dv_cnt = 0;
        end
        if (anOutDrawValid) begin
            dv_cnt++;
            aDrawReady = (dv_cnt > drw_hold);
        end else begin
            aDrawReady = 1'b0;
        end

        if (p_cv && p_cr) begin
            sb_pop(ev);
            chk("clear_kind", 64'(ev.kind), 64'd8);
            chk("clear_payload", p_cc, ev.val);
            chk("clear_valid_cycles", 64'(cv_cnt), 64'(clr_hold + 1));
            chk("clear_valid_drop", anOutClearValid, 1'b0);
            cv_cnt = 0;
        end
        if (anOutClearValid) cv_cnt++;
        aClearReady = clr_tied || (anOutClearValid && (cv_cnt > clr_hold));

        if (anOutDone) begin
            done_pulses++;
            sb_pop(ev);
            chk("done_kind", 64'(ev.kind), 64'd1);
            chk("done_count", anOutCommandCount, ev.val);
        end
    endtask

    task automatic run(input string name, input int max_cyc);
        int n_exp;
        int k;
        bit idle;
        n_exp = fq.size();
        last_req = -1;
        req_pulses = 0;
        done_pulses = 0;
        drive_feeder();
        k = 0;
        idle = 1'b0;
        while (!idle && k < max_cyc) begin
            tick();
            k++;
            idle = (fq.size() == 0) && !anOutBusy;
        end
        chk({name, "_completed"}, idle, 1'b1);
        chk({name, "_req_pulses"}, 64'(req_pulses), 64'(n_exp));
        chk({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req"}, anOutCommandRequested, 1'b0);
        chk({tag, "_draw_valid"}, anOutDrawValid, 1'b0);
        chk({tag, "_clear_valid"}, anOutClearValid, 1'b0);
        chk({tag, "_done"}, anOutDone, 1'b0);
        chk({tag, "_busy"}, anOutBusy, 1'b0);
    endtask

    initial begin
        aReset = 1'b0;
        aDrawReady = 1'b0;
        aClearReady = 1'b0;
        model_reset();
        drive_feeder();
        #1;
        chk_regs("reset");
        chk_idle_outputs("reset");
        repeat (2) @(posedge aClock);
        #1;
        aReset = 1'b1;
        tick();

        // Clear colour assembled from halves, then END.
        push_cmd(SET_CLEAR_COLOR_LO, 16'h00FF);
        push_cmd(SET_CLEAR_COLOR_HI, 16'h8040);
        push_cmd(END, 16'h0);
        run("colour", 60);
        chk("colour_value", anOutClearColor, 32'h804000FF);
        chk("colour_done_pulses", 64'(done_pulses), 64'd1);
        chk("colour_count", anOutCommandCount, 16'd3);
        chk_regs("colour");

        // DRAW with back end stalling for 5 cycles, followed by a NOP.
        drw_hold = 5;
        push_cmd(SET_VERTEX_BASE_LO, 16'h1000);
        push_cmd(SET_VERTEX_BASE_HI, 16'h0002);
        push_cmd(DRAW, 16'd36);
        push_cmd(NOP, 16'h0);
        run("draw", 80);
        chk("draw_base", anOutVertexBase, 32'h00021000);
        chk("draw_count_reg", anOutDrawCount, 16'd36);
        chk_regs("draw");
        drw_hold = 0;

        // CLEAR with ready held high throughout, including outside valid.
        clr_tied = 1'b1;
        aClearReady = 1'b1;
        push_cmd(CLEAR, 16'h0);
        push_cmd(CLEAR, 16'h0);
        push_cmd(NOP, 16'h0);
        run("clear", 60);
        chk_regs("clear");
        clr_tied = 1'b0;
        aClearReady = 1'b0;

        // Illegal opcode is sticky and execution continues.
        push_cmd(16'h00FF, 16'h1234);
        push_cmd(SET_VIEWPORT_WIDTH, 16'd640);
        push_cmd(SET_VIEWPORT_HEIGHT, 16'd480);
        push_cmd(END, 16'h0);
        run("illegal", 60);
        chk("illegal_error", anOutError, 1'b1);
        chk("illegal_width", anOutViewportWidth, 16'd640);
        chk_regs("illegal");
        chk_idle_outputs("illegal_idle");

        // Back-to-back random state writes with one short-stalled DRAW.
        drw_hold = 2;
        for (int i = 0; i < 12; i++)
            push_cmd(16'($urandom_range(2, 7)), 16'($urandom));
        push_cmd(DRAW, 16'($urandom));
        push_cmd(SET_VIEWPORT_HEIGHT, 16'($urandom));
        push_cmd(END, 16'h0);
        run("stream", 120);
        chk_regs("stream");
        drw_hold = 0;

        // Asynchronous reset while a DRAW is stalled.
        drw_hold = 1000;
        push_cmd(DRAW, 16'd7);
        drive_feeder();
        for (int i = 0; i < 20 && !anOutDrawValid; i++) tick();
        chk("rst_draw_reached", anOutDrawValid, 1'b1);
        #2;
        aReset = 1'b0;
        #1;
        chk("rst_draw_valid_async", anOutDrawValid, 1'b0);
        fq.delete();
        sb.delete();
        model_reset();
        drive_feeder();
        aDrawReady = 1'b0;
        dv_cnt = 0;
        drw_hold = 0;
        chk_regs("rst_mid_draw");
        chk_idle_outputs("rst_mid_draw");
        @(posedge aClock);
        #1;
        aReset = 1'b1;
        tick();

        push_cmd(SET_VIEWPORT_WIDTH, 16'd5);
        push_cmd(END, 16'h0);
        run("post_reset", 40);
        chk_regs("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
